seq_detect_prog: RTL and testbench
==================================

# seq_detect_prog

Parametrised, programmable serial bit-pattern detector: the next generation of our fixed-pattern Mealy detectors. It shifts in one bit per qualified clock and compares the last PAT_W bits against a run-time loaded pattern with a per-bit don't-care mask. It supports overlapping or non-overlapping matches and keeps a saturating match counter. It sits on a serial data stream as a flag generator for downstream control logic.

## Interface
- PAT_W, 4, pattern length in bits; legal range 2..16.
- CNT_W, 8, match counter width; legal range 1..16.

- Clk  in  1  single clock; all state updates on rising edge.
- Rst  in  1  asynchronous, active-low reset; assertion clears all state immediately.
- en  in  1  bit-valid qualifier; w is sampled only when en=1.
- w  in  1  serial data bit.
- load  in  1  one-cycle pulse; captures pat and mask and clears history.
- pat  in  PAT_W  pattern; pat[PAT_W-1] is the oldest bit and pat[0] the newest.
- mask  in  PAT_W  compare enable per bit; 1 means compare, 0 means don't-care.
- overlap  in  1  1 = overlapping matches allowed; sampled live on every qualified bit.
- cnt_clr  in  1  synchronous clear of match_cnt.
- z  out  1  registered match pulse.
- match_cnt  out  CNT_W  saturating count of matches since reset or clear.
- armed  out  1  high when the history window holds PAT_W valid bits.

## Operation
- Registers:
  - hist[PAT_W-1:0]: newest bit in hist[0].
  - fill: 0..PAT_W.
  - pat_r and mask_r.
  - z, match_cnt.
- State machine, derived from fill:
  - FILL when fill < PAT_W.
  - HUNT when fill == PAT_W.
  - armed = (fill == PAT_W), registered.
- Qualified bit (en=1, load=0):
  - nh = {hist[PAT_W-2:0], w}.
  - nf = min(fill+1, PAT_W).
  - hist <= nh.
- Match condition:
  - nf == PAT_W, AND
  - mask_r != 0, AND
  - ((nh ^ pat_r) & mask_r) == 0.
- On match:
  - z <= 1.
  - match_cnt <= match_cnt+1, saturating at 2^CNT_W-1.
  - fill <= overlap ? PAT_W : 0. With overlap=0 the history is discarded and the machine returns to FILL.
- On no match: z <= 0, fill <= nf.
- en=0 and load=0:
  - hist, fill and match_cnt hold.
  - z <= 0.
- load=1 (priority over en):
  - pat_r <= pat, mask_r <= mask.
  - hist <= 0, fill <= 0, z <= 0.
  - w is ignored that cycle.
  - match_cnt is unaffected.
- mask_r == 0 disables detection: z never asserts, but history still shifts and armed still sets.
- cnt_clr=1:
  - match_cnt <= 0.
  - If a match occurs in the same cycle, match_cnt <= 1. The match is never lost.
- Reset values: hist=0, fill=0, pat_r=0, mask_r=0, z=0, match_cnt=0, armed=0. The block is disabled until the first load.

## Timing
- Latency: z rises in the cycle immediately after the edge that samples the final pattern bit. That is one cycle, same as the fixed detectors.
- z is high for exactly one cycle per match.
- Back-to-back qualified matches with overlap=1 hold z high continuously, one count per cycle.
- match_cnt updates on the same edge that sets z.
- armed rises on the edge that accepts the PAT_W-th bit after load or reset. It also rises after a non-overlap match once PAT_W fresh bits have been accepted.
- Gaps in en do not break a match: window continuity counts qualified bits only.
- Asynchronous Rst assertion mid-stream:
  - z, match_cnt and armed go to 0 without waiting for a clock edge.
  - Release is synchronous to the next Clk edge; the first edge after release must not capture w.
- load and a completing bit in the same cycle: load wins, and no match is reported.

## Test plan
- PAT_W=4, load pat=1001 mask=1111 overlap=1, stream 1,0,0,1,0,0,1 with en=1 → z pulses after bits 4 and 7; match_cnt=2.
- Same pattern with overlap=0, same stream → single z pulse after bit 4; match_cnt=1; armed drops to 0 after the match.
- load pat=1000 mask=1001, stream 1,1,1,0 → z after bit 4. Stream 0,1,1,0 → no z.
- CNT_W=3, pat=1111 mask=1111 overlap=1, 12 consecutive ones → z high continuously from bit 4 to bit 12 (9 matches); match_cnt saturates at 7. Then assert cnt_clr concurrent with another match → match_cnt=1.
- Stream 1,0 then en low 5 cycles, then 0,1 (pat=1001) → z after the final bit; hist holds during the gap. Assert load mid-window → fill=0, no match on the completing bit.
- Drive Rst low asynchronously mid-cycle while z=1 → z=0 and match_cnt=0 immediately. After release, stream 1001 without load → no z, because mask_r=0.

Source files
------------

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: compares the last PAT_W qualified bits
// against a loaded pattern/mask, with optional overlap and a saturating match count.
module seq_detect_prog #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             en,
    input  logic             w,
    input  logic             load,
    input  logic [PAT_W-1:0] pat,
    input  logic [PAT_W-1:0] mask,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [0:0]        ST_FILL   = 1'b0;
    localparam logic [0:0]        ST_HUNT   = 1'b1;

    logic [PAT_W-1:0]  hist_reg, hist_next;
    logic [FILL_W-1:0] fill_reg, fill_next;
    logic [PAT_W-1:0]  pat_reg, pat_next;
    logic [PAT_W-1:0]  mask_reg, mask_next;
    logic              z_reg, z_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [0:0]        state_reg, state_next;
    // Low for the first edge after reset release so that edge never captures w.
    logic              live_reg;

    logic [PAT_W-1:0]  nh;
    logic [FILL_W-1:0] nf;
    logic [PAT_W-1:0]  bit_miss;
    logic              qual;
    logic              hit;

    assign nh   = {hist_reg[PAT_W-2:0], w};
    assign nf   = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + 1'b1;
    assign qual = en & ~load & live_reg;

    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
            assign bit_miss[gi] = mask_reg[gi] & (nh[gi] ^ pat_reg[gi]);
        end
    endgenerate

    // An all-zero mask would otherwise match everything; treat it as disabled.
    assign hit = qual && (nf == FILL_FULL) && (|mask_reg) && !(|bit_miss);

    always_comb begin
        hist_next = hist_reg;
        fill_next = fill_reg;
        pat_next  = pat_reg;
        mask_next = mask_reg;
        z_next    = 1'b0;
        cnt_next  = cnt_reg;

        if (load) begin
            pat_next  = pat;
            mask_next = mask;
            hist_next = '0;
            fill_next = '0;
        end else if (qual) begin
            hist_next = nh;
            z_next    = hit;
            if (hit) begin
                fill_next = overlap ? FILL_FULL : '0;
            end else begin
                fill_next = nf;
            end
        end

        if (cnt_clr) begin
            cnt_next = hit ? CNT_W'(1) : '0;
        end else if (hit && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end

        state_next = (fill_next == FILL_FULL) ? ST_HUNT : ST_FILL;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hist_reg  <= '0;
            fill_reg  <= '0;
            pat_reg   <= '0;
            mask_reg  <= '0;
            z_reg     <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= ST_FILL;
            live_reg  <= 1'b0;
        end else begin
            hist_reg  <= hist_next;
            fill_reg  <= fill_next;
            pat_reg   <= pat_next;
            mask_reg  <= mask_next;
            z_reg     <= z_next;
            cnt_reg   <= cnt_next;
            state_reg <= state_next;
            live_reg  <= 1'b1;
        end
    end

    assign z         = z_reg;
    assign match_cnt = cnt_reg;
    assign armed     = (state_reg == ST_HUNT);

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog (PAT_W=4, CNT_W=3) with hand-computed expectations.
module tb_seq_detect_prog;

    localparam int PAT_W = 4;
    localparam int CNT_W = 3;

    logic             Clk;
    logic             Rst;
    logic             en;
    logic             w;
    logic             load;
    logic [PAT_W-1:0] pat;
    logic [PAT_W-1:0] mask;
    logic             overlap;
    logic             cnt_clr;
    logic             z;
    logic [CNT_W-1:0] match_cnt;
    logic             armed;

    int checks = 0;
    int errors = 0;

    seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .en        (en),
        .w         (w),
        .load      (load),
        .pat       (pat),
        .mask      (mask),
        .overlap   (overlap),
        .cnt_clr   (cnt_clr),
        .z         (z),
        .match_cnt (match_cnt),
        .armed     (armed)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: controls applied on the falling edge, outputs sampled 1 after the rising edge.
    task automatic cyc(input logic e, input logic b, input logic ld, input logic clr);
        @(negedge Clk);
        en = e; w = b; load = ld; cnt_clr = clr;
        @(posedge Clk);
        #1;
        $display("t=%0t en=%b w=%b load=%b clr=%b -> z=%b cnt=%0d armed=%b",
                 $time, e, b, ld, clr, z, match_cnt, armed);
    endtask

    task automatic bitin(input logic b);
        cyc(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic do_load(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m);
        pat = p; mask = m;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        Rst = 1'b0; en = 1'b0; w = 1'b0; load = 1'b0; cnt_clr = 1'b0;
        pat = '0; mask = '0; overlap = 1'b1;

        // Reset state
        #12;
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        @(negedge Clk); Rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Overlapping 1001 on stream 1001001
        overlap = 1'b1;
        do_load(4'b1001, 4'b1111);
        bitin(1); bitin(0); bitin(0);
        chk("ov_b3_z", 32'(z), 32'd0);
        chk("ov_b3_armed", 32'(armed), 32'd0);
        bitin(1);
        chk("ov_b4_z", 32'(z), 32'd1);
        chk("ov_b4_armed", 32'(armed), 32'd1);
        chk("ov_b4_cnt", 32'(match_cnt), 32'd1);
        bitin(0);
        chk("ov_b5_z", 32'(z), 32'd0);
        bitin(0); bitin(1);
        chk("ov_b7_z", 32'(z), 32'd1);
        chk("ov_b7_cnt", 32'(match_cnt), 32'd2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ov_idle_z", 32'(z), 32'd0);
        chk("ov_idle_cnt", 32'(match_cnt), 32'd2);

        // Non-overlapping on the same stream
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_cnt", 32'(match_cnt), 32'd0);
        overlap = 1'b0;
        do_load(4'b1001, 4'b1111);
        bitin(1); bitin(0); bitin(0); bitin(1);
        chk("nov_b4_z", 32'(z), 32'd1);
        chk("nov_b4_cnt", 32'(match_cnt), 32'd1);
        chk("nov_b4_armed", 32'(armed), 32'd0);
        bitin(0); bitin(0); bitin(1);
        chk("nov_b7_z", 32'(z), 32'd0);
        chk("nov_b7_cnt", 32'(match_cnt), 32'd1);
        chk("nov_b7_armed", 32'(armed), 32'd0);

        // Masked pattern 1x x0
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        overlap = 1'b1;
        do_load(4'b1000, 4'b1001);
        bitin(1); bitin(1); bitin(1); bitin(0);
        chk("msk_hit_z", 32'(z), 32'd1);
        do_load(4'b1000, 4'b1001);
        bitin(0); bitin(1); bitin(1); bitin(0);
        chk("msk_miss_z", 32'(z), 32'd0);
        chk("msk_miss_armed", 32'(armed), 32'd1);
        chk("msk_cnt", 32'(match_cnt), 32'd1);

        // Twelve ones on 1111: continuous z, counter saturates at 7
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        do_load(4'b1111, 4'b1111);
        for (int i = 1; i <= 12; i++) begin
            bitin(1);
            chk($sformatf("sat_z_b%0d", i), 32'(z), (i >= 4) ? 32'd1 : 32'd0);
            chk($sformatf("sat_cnt_b%0d", i), 32'(match_cnt),
                (i < 4) ? 32'd0 : ((i - 3 > 7) ? 32'd7 : 32'(i - 3)));
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_hit_z", 32'(z), 32'd1);
        chk("clr_hit_cnt", 32'(match_cnt), 32'd1);

        // Gap in en keeps the window; load mid-window discards it
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        do_load(4'b1001, 4'b1111);
        bitin(1); bitin(0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("gap_z", 32'(z), 32'd0);
        chk("gap_armed", 32'(armed), 32'd0);
        bitin(0); bitin(1);
        chk("gap_done_z", 32'(z), 32'd1);
        chk("gap_done_cnt", 32'(match_cnt), 32'd1);
        bitin(1); bitin(0); bitin(0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("ld_win_z", 32'(z), 32'd0);
        chk("ld_win_armed", 32'(armed), 32'd0);
        chk("ld_win_cnt", 32'(match_cnt), 32'd1);
        bitin(1);
        chk("ld_after_z", 32'(z), 32'd0);

        // Build a match, then assert reset mid-cycle while z is high
        bitin(0); bitin(0); bitin(1);
        chk("pre_rst_z", 32'(z), 32'd1);
        chk("pre_rst_cnt", 32'(match_cnt), 32'd2);
        #2;
        Rst = 1'b0;
        #1;
        chk("async_z", 32'(z), 32'd0);
        chk("async_cnt", 32'(match_cnt), 32'd0);
        chk("async_armed", 32'(armed), 32'd0);

        // Release: the first edge must not take w, and mask_r=0 blocks matches
        @(negedge Clk);
        Rst = 1'b1; en = 1'b1; w = 1'b1; load = 1'b0; cnt_clr = 1'b0;
        @(posedge Clk);
        #1;
        chk("rel_first_armed", 32'(armed), 32'd0);
        bitin(0); bitin(0); bitin(1);
        chk("rel_b3_armed", 32'(armed), 32'd0);
        chk("rel_b3_z", 32'(z), 32'd0);
        bitin(1);
        chk("rel_b4_armed", 32'(armed), 32'd1);
        chk("rel_b4_z", 32'(z), 32'd0);
        bitin(0); bitin(0); bitin(1);
        chk("nomask_z", 32'(z), 32'd0);
        chk("nomask_cnt", 32'(match_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
